fifo_stream_drain: RTL and testbench
====================================

Name: fifo_stream_drain

Overview:
- Downstream neighbour of the synchronous pointer FIFO (sync_fifo_ptr).
- Drains the FIFO read port (rd_en / registered dout with 1-cycle read latency / empty) and presents the words as a valid/ready stream.
- A 2-entry output buffer absorbs the read latency, so the consumer may drop out_ready on any cycle without loss or duplication.
- Sustains 1 word/cycle when the FIFO is non-empty and out_ready is held high.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- CNT_W, 16, width of the optional beat counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous clear of buffer and in-flight read.
- fifo_rd_en  output  1  read strobe to the FIFO rd_en.
- fifo_dout  input  WIDTH  FIFO dout, valid the cycle after an accepted read.
- fifo_empty  input  1  FIFO empty flag.
- out_valid  output  1  stream word valid.
- out_data  output  WIDTH  stream word.
- out_ready  input  1  consumer ready.
- beat_cnt  output  CNT_W  delivered-beat counter; present only with the optional feature.

Behaviour:
- Reset: synchronous, rst_n low sampled at posedge.
  - buffer count=0, head=0, tail=0, inflight=0.
  - out_valid=0, out_data=0, fifo_rd_en=0, beat_cnt=0.
- State:
  - 2-entry register buffer buf[0:1].
  - 1-bit head and tail pointers, wrap 1->0.
  - count 0..2.
  - inflight flag = read issued last cycle.
- pop = out_valid && out_ready.
- out_valid = (count != 0); out_data = buf[head].
  - Both are registered-state driven, with no combinational path from out_ready.
- fifo_rd_en is combinational:
  - asserted when !fifo_empty && !flush && (count+inflight <= 1 || (count+inflight == 2 && pop)).
  - Never asserted when fifo_empty=1; an underflow strobe is forbidden.
- inflight <= fifo_rd_en each cycle.
- When inflight=1: buf[tail] <= fifo_dout, tail++, count++.
- On pop: head++, count--.
- Simultaneous capture and pop: count unchanged, both pointers advance.
- Latency: FIFO non-empty with buffer empty -> fifo_rd_en same cycle -> out_valid high 2 edges later.
- Throughput: with out_ready=1 and FIFO never empty, one beat per cycle after the 2-cycle fill.
- Backpressure hold: out_ready=0 while out_valid=1 -> out_data stable until accepted.
  - Buffer fills to 2 and fifo_rd_en deasserts.
- Overflow safety: count+inflight never exceeds 2; a capture never finds count=2 unless a pop occurs in the same cycle.
- Order: strictly FIFO order, no drop, no duplicate.
- flush=1 at posedge:
  - count, head, tail and inflight cleared; an in-flight word is discarded; out_valid=0 next cycle.
  - fifo_rd_en is held 0 during the flush cycle.
- Reset mid-transfer: identical to flush plus beat_cnt cleared.
  - Words already read from the FIFO are lost; this is accepted.

Optional Feature:
- Macro: STREAM_DRAIN_CNT_EN.
- Defined:
  - beat_cnt port exists; increments by 1 on every pop and wraps at 2^CNT_W-1 -> 0.
  - Cleared by reset only, not by flush.
- Undefined:
  - beat_cnt port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package/header (fifo_defs): default WIDTH, FIFO read-latency constant (1), buffer depth constant (2).
- Sub-module stream_skid_buf2: the 2-entry buffer with push/pop/count/head/tail.
- Top level contains only the fifo_rd_en issue logic, inflight flag, flush and counter.

Test Plan:
- Reset with FIFO (DEPTH=8) preloaded with 0x11,0x22,0x33 and out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, first beat 2 cycles after rst_n rises; then out_valid=0 and fifo_rd_en=0 with empty=1.
- Preload 0xA0..0xA7, out_ready=0 for 10 cycles -> exactly 2 reads issued, out_data holds 0xA0; release ready -> 0xA0..0xA7 in order, no gaps after refill.
- Random out_ready (50%) over 200 random words -> scoreboard order match; fifo_rd_en never high with fifo_empty=1; count never >2.
- Assert flush the cycle after a read issues with words 0x55,0x66 queued -> out_valid=0 next cycle; the in-flight word is never output; the next output is the following FIFO word.
- Drive rst_n=0 mid-stream, then release -> all outputs 0; with STREAM_DRAIN_CNT_EN, beat_cnt=0.
- With STREAM_DRAIN_CNT_EN and CNT_W=4, 17 beats -> beat_cnt=1 (wrap); a flush leaves beat_cnt unchanged.

Source files
------------

// File: rtl/fifo_stream_drain_pkg.sv
// Shared constants for the FIFO stream drain: default word width, FIFO read
// latency and depth of the output buffer that absorbs that latency.
package fifo_stream_drain_pkg;

  localparam int DefaultWidth    = 8;
  localparam int FifoReadLatency = 1;
  localparam int BufDepth        = 2;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry register buffer with 1-bit head/tail pointers; the head entry is
// presented as a registered valid/data pair.
module stream_skid_buf2
  import fifo_stream_drain_pkg::*;
#(
  parameter int WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] slot_q [BufDepth];
  logic [1:0]       count_q, count_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;

  // Pointers are single bits, so advancing is an inversion that wraps 1 -> 0.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (push_i) tail_d = ~tail_q;
      if (pop_i)  head_d = ~head_q;
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= 2'd0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (push_i && !flush_i) slot_q[tail_q] <= pushData_i;
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != 2'd0);
  assign data_o  = slot_q[head_q];

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream.
// Optional delivered-beat counter port beat_cnt: define STREAM_DRAIN_CNT_EN.
module fifo_stream_drain
  import fifo_stream_drain_pkg::*;
#(
  parameter int WIDTH = DefaultWidth,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef STREAM_DRAIN_CNT_EN
  ,
  output logic [CNT_W-1:0] beat_cnt
`endif
);

  logic [1:0] count;
  logic [2:0] occupancy;
  logic       inflight_q;
  logic       pop;

  if (FifoReadLatency != 1 || CNT_W < 1) begin : gBadConfig
    $error("fifo_stream_drain: unsupported read latency or CNT_W");
  end

  assign pop       = out_valid && out_ready;
  assign occupancy = {1'b0, count} + {2'b00, inflight_q};

  // A read is issued only when its word is guaranteed a free slot at capture.
  assign fifo_rd_en = rst_n && !fifo_empty && !flush &&
                      ((occupancy <= 3'(BufDepth - 1)) ||
                       ((occupancy == 3'(BufDepth)) && pop));

  always_ff @(posedge clk) begin
    if (!rst_n || flush) inflight_q <= 1'b0;
    else                 inflight_q <= fifo_rd_en;
  end

  stream_skid_buf2 #(
    .WIDTH(WIDTH)
  ) uBuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .push_i     (inflight_q),
    .pushData_i (fifo_dout),
    .pop_i      (pop),
    .count_o    (count),
    .valid_o    (out_valid),
    .data_o     (out_data)
  );

`ifdef STREAM_DRAIN_CNT_EN
  logic [CNT_W-1:0] beatCnt_q;

  // Counts delivered beats; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n)   beatCnt_q <= '0;
    else if (pop) beatCnt_q <= beatCnt_q + CNT_W'(1);
  end

  assign beat_cnt = beatCnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Randomized bench for fifo_stream_drain: a queue-based FIFO model upstream and
// a scoreboard of read-but-undelivered words checking the output stream.
module tb_fifo_stream_drain;

  localparam int Width     = 8;
  localparam int CntW      = 4;
  localparam int FifoDepth = 8;

  logic             clk = 1'b0;
  logic             rstN;
  logic             flush;
  logic             fifoRdEn;
  logic [Width-1:0] fifoDout = '0;
  logic             fifoEmpty;
  logic             outValid;
  logic [Width-1:0] outData;
  logic             outReady;
`ifdef STREAM_DRAIN_CNT_EN
  logic [CntW-1:0]  beatCnt;
`endif

  int               assertCount = 0;
  int               failCount   = 0;
  logic [Width-1:0] fifoQ [$];
  logic [Width-1:0] readQ [$];
  int               fifoLevel    = 0;
  int               readCount    = 0;
  int               popCount     = 0;
  int               beatModel    = 0;
  int               underflowCnt = 0;
  int               overCnt      = 0;
  logic             rdSample     = 1'b0;
  logic [Width-1:0] lastPop      = '0;

  fifo_stream_drain #(
    .WIDTH(Width),
    .CNT_W(CntW)
  ) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .flush      (flush),
    .fifo_rd_en (fifoRdEn),
    .fifo_dout  (fifoDout),
    .fifo_empty (fifoEmpty),
    .out_valid  (outValid),
    .out_data   (outData),
    .out_ready  (outReady)
`ifdef STREAM_DRAIN_CNT_EN
    ,
    .beat_cnt   (beatCnt)
`endif
  );

  always #5 clk = ~clk;

  assign fifoEmpty = (fifoLevel == 0);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic flushIn);
    @(posedge clk);
    #1;
    outReady = ready;
    flush    = flushIn;
  endtask

  task automatic pushWord(input logic [Width-1:0] w);
    fifoQ.push_back(w);
    fifoLevel++;
  endtask

  task automatic drainAll(input string tag);
    int guard = 0;
    outReady = 1'b1;
    while ((readQ.size() != 0 || fifoLevel != 0) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput(tag, 32'(guard < 200), 32'd1);
    applyStimulus(1'b1, 1'b0);
  endtask

  // Upstream FIFO: word appears on dout the cycle after an accepted read.
  always @(posedge clk) begin
    if (rdSample && fifoLevel > 0) begin
      logic [Width-1:0] w;
      w = fifoQ.pop_front();
      fifoLevel--;
      fifoDout <= w;
      readQ.push_back(w);
      readCount++;
    end
  end

  // Scoreboard decides what the coming edge does, sampled mid-cycle.
  always @(negedge clk) begin
    logic [Width-1:0] expWord;
    rdSample = fifoRdEn;
    if (fifoRdEn && fifoEmpty) underflowCnt++;
    if (readQ.size() > 2) overCnt++;
    if (rstN && outValid && outReady) begin
      popCount++;
      lastPop = outData;
      if (readQ.size() == 0) begin
        checkOutput("spuriousBeat", 32'd1, 32'd0);
      end else begin
        expWord = readQ.pop_front();
        checkOutput("scoreboard", 32'(outData), 32'(expWord));
      end
    end
    if (!rstN) beatModel = 0;
    else if (outValid && outReady) beatModel++;
    if (!rstN || flush) readQ.delete();
  end

  initial begin
    int base;
    int guard;
    int pushed;
    rstN     = 1'b0;
    flush    = 1'b0;
    outReady = 1'b0;

    // Reset with a preloaded FIFO: nothing may be read while in reset.
    pushWord(8'h11);
    pushWord(8'h22);
    pushWord(8'h33);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetValid", 32'(outValid), 32'd0);
    checkOutput("resetData", 32'(outData), 32'd0);
    checkOutput("resetRdEn", 32'(fifoRdEn), 32'd0);
`ifdef STREAM_DRAIN_CNT_EN
    checkOutput("resetBeatCnt", 32'(beatCnt), 32'd0);
`endif
    outReady = 1'b1;
    rstN     = 1'b1;
    guard    = 0;
    while (!outValid && guard < 10) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("firstBeatLatency", guard, 32'd2);
    checkOutput("beat0", 32'(outData), 32'h11);
    @(posedge clk); #1;
    checkOutput("beat1", 32'(outData), 32'h22);
    @(posedge clk); #1;
    checkOutput("beat2", 32'(outData), 32'h33);
    @(posedge clk); #1;
    checkOutput("idleValid", 32'(outValid), 32'd0);
    checkOutput("idleRdEn", 32'(fifoRdEn), 32'd0);

    // Backpressure: buffer fills to two and the head word holds.
    outReady  = 1'b0;
    readCount = 0;
    for (int i = 0; i < 8; i++) pushWord(8'hA0 + 8'(i));
    repeat (10) @(posedge clk);
    #1;
    checkOutput("holdReads", readCount, 32'd2);
    checkOutput("holdData", 32'(outData), 32'hA0);
    checkOutput("holdValid", 32'(outValid), 32'd1);
    checkOutput("holdRdEn", 32'(fifoRdEn), 32'd0);
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("releaseValid", 32'(outValid), 32'd1);
      checkOutput("releaseData", 32'(outData), 32'hA0 + 32'(i));
      @(posedge clk);
      #1;
    end
    checkOutput("releaseDone", 32'(outValid), 32'd0);

    // Random ready and random arrivals over 200 words.
    base   = popCount;
    pushed = 0;
    while (pushed < 200) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'b0);
      if (fifoLevel < FifoDepth && $urandom_range(0, 1) == 1) begin
        pushWord(8'($urandom));
        pushed++;
      end
    end
    drainAll("randomDrain");
    checkOutput("randomDelivered", popCount - base, 32'd200);

    // Flush the cycle after a read issues: that in-flight word is discarded.
    outReady = 1'b0;
    pushWord(8'h55);
    pushWord(8'h66);
    pushWord(8'h77);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flushRdEn", 32'(fifoRdEn), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("flushValid", 32'(outValid), 32'd0);
    base  = popCount;
    guard = 0;
    while (popCount == base && guard < 10) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("flushNextWord", 32'(lastPop), 32'h66);
    drainAll("flushDrain");

    // Reset in the middle of a stream.
    for (int i = 0; i < 6; i++) pushWord(8'($urandom));
    repeat (5) applyStimulus(1'($urandom_range(0, 1)), 1'b0);
    rstN = 1'b0;
    fifoQ.delete();
    fifoLevel = 0;
    @(posedge clk);
    #1;
    checkOutput("midResetValid", 32'(outValid), 32'd0);
    checkOutput("midResetData", 32'(outData), 32'd0);
    checkOutput("midResetRdEn", 32'(fifoRdEn), 32'd0);
    rstN = 1'b1;
    checkOutput("postResetValid", 32'(outValid), 32'd0);
    checkOutput("postResetData", 32'(outData), 32'd0);
`ifdef STREAM_DRAIN_CNT_EN
    checkOutput("postResetBeatCnt", 32'(beatCnt), 32'd0);

    // Seventeen beats wrap a 4-bit counter to 1; flush leaves it alone.
    for (int i = 0; i < 17; i++) begin
      pushWord(8'(i));
      applyStimulus(1'b1, 1'b0);
    end
    drainAll("cntDrain");
    checkOutput("beatCntWrap", 32'(beatCnt), 32'd1);
    checkOutput("beatCntModel", 32'(beatCnt), 32'(beatModel % 16));
    outReady = 1'b0;
    pushWord(8'h99);
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("beatCntFlush", 32'(beatCnt), 32'd1);
`endif

    checkOutput("underflowStrobes", underflowCnt, 32'd0);
    checkOutput("occupancyOver2", overCnt, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
